// File: rtl/strip_sequencer_pkg.sv
// rtl/strip_sequencer_pkg.sv - shared types, FSM encodings and colour packing for the LED strip sequencer
//
// Purpose : constants and helpers imported by the strip sequencer and its bit serializer.
// Contents: COLOR_W / BITS_PER_PIXEL, FSM state encodings (IDLE, LOAD, DRAIN, PAUSE),
//           color_t / state_t types, pack_grb() which orders a pixel as sent on the wire.
package strip_pkg;

    localparam int COLOR_W        = 24;
    localparam int BITS_PER_PIXEL = 24;

    typedef logic [1:0]         state_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t PAUSE = 2'd3;

    // The strip expects green first, then red, then blue, each MSB first.
    function automatic color_t pack_grb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/strip_sequencer_if.sv
// rtl/strip_sequencer_if.sv - buffer-write, frame-control and serial-line bundle of the strip sequencer
//
// Purpose: groups every non-clock signal of strip_sequencer.
// Signals: wr_en/wr_addr/wr_r/wr_g/wr_b  buffer write request (master -> slave)
//          wr_err                        dropped-write pulse     (slave -> master)
//          start                         frame request           (master -> slave)
//          busy/done                     frame status            (slave -> master)
//          out                           serial line to strip    (slave -> master)
interface strip_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_r;
    logic [7:0]        wr_g;
    logic [7:0]        wr_b;
    logic              wr_err;
    logic              start;
    logic              busy;
    logic              done;
    logic              out;

    modport master (
        output wr_en, wr_addr, wr_r, wr_g, wr_b, start,
        input  wr_err, busy, done, out
    );

    modport slave (
        input  wr_en, wr_addr, wr_r, wr_g, wr_b, start,
        output wr_err, busy, done, out
    );
endinterface

// File: rtl/strip_sequencer_bit_tx.sv
// rtl/strip_sequencer_bit_tx.sv - one-wire pulse-width bit serializer with a one-word holding register
//
// Purpose: accepts 24-bit words on a valid/ready handshake and sends them MSB first,
//          gaplessly, each bit DATA_TICKS cycles long and high for T0H (0) or T1H (1) cycles.
// Ports  : clk, rst (async, active low)
//          i_valid/i_word/o_ready  word handshake; ready while the holding register is empty
//          o_out                   serial line
//          o_idle                  nothing shifting and nothing held
module strip_bit_tx
    import strip_pkg::*;
#(
    parameter int DATA_TICKS = 6,
    parameter int T0H        = 2,
    parameter int T1H        = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  color_t i_word,
    output logic   o_ready,
    output logic   o_out,
    output logic   o_idle
);

    localparam int TICK_W = (DATA_TICKS > 1) ? $clog2(DATA_TICKS) : 1;
    localparam int BIT_W  = $clog2(BITS_PER_PIXEL);

    color_t            r_hold;
    color_t            r_shift;
    logic              r_hold_full;
    logic              r_active;
    logic [TICK_W-1:0] r_tick;
    logic [BIT_W-1:0]  r_bit;

    logic              w_tick_end;
    logic              w_word_end;
    logic              w_promote;
    logic              w_accept;
    logic [TICK_W-1:0] w_high_ticks;

    assign w_tick_end   = (r_tick == TICK_W'(DATA_TICKS - 1));
    assign w_word_end   = r_active && w_tick_end && (r_bit == BIT_W'(BITS_PER_PIXEL - 1));
    // A held word moves into the shifter either straight away (line idle) or on the
    // last tick of the current word, so the next bit follows with no gap.
    assign w_promote    = r_hold_full && (!r_active || w_word_end);
    assign w_accept     = i_valid && !r_hold_full;
    assign w_high_ticks = r_shift[COLOR_W-1] ? TICK_W'(T1H) : TICK_W'(T0H);

    assign o_ready = !r_hold_full;
    assign o_out   = r_active && (r_tick < w_high_ticks);
    assign o_idle  = !r_active && !r_hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_shift     <= '0;
            r_hold_full <= 1'b0;
            r_active    <= 1'b0;
            r_tick      <= '0;
            r_bit       <= '0;
        end else begin
            // accept and promote are mutually exclusive: one needs the holder empty, the other full
            if (w_accept) begin
                r_hold      <= i_word;
                r_hold_full <= 1'b1;
            end else if (w_promote) begin
                r_hold_full <= 1'b0;
            end

            if (w_promote) begin
                r_shift  <= r_hold;
                r_active <= 1'b1;
                r_tick   <= '0;
                r_bit    <= '0;
            end else if (r_active) begin
                if (w_tick_end) begin
                    r_tick  <= '0;
                    r_shift <= r_shift << 1;
                    if (w_word_end) begin
                        r_active <= 1'b0;
                        r_bit    <= '0;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/strip_sequencer.sv
// rtl/strip_sequencer.sv - WS2812-style strip frame controller: pixel buffer, write checks, frame FSM
//
// Purpose: holds NUM_PIXELS GRB words, and on start streams them all through strip_bit_tx,
//          then holds the line low for PAUSE_TICKS cycles (latch time) before going idle.
// Ports  : clk, rst (async, active low)
//          bus (strip_sequencer_if.slave): wr_en/wr_addr/wr_r/wr_g/wr_b in, wr_err out,
//          start in, busy/done out, out (serial line) out.
module strip_sequencer
    import strip_pkg::*;
#(
    parameter int NUM_PIXELS  = 8,
    parameter int ADDR_W      = 3,
    parameter int DATA_TICKS  = 6,
    parameter int PAUSE_TICKS = 12,
    parameter int T0H         = 2,
    parameter int T1H         = 4
) (
    input  logic               clk,
    input  logic               rst,
    strip_sequencer_if.slave   bus
);

    localparam int PCNT_W = $clog2(PAUSE_TICKS + 1);
    localparam int DEPTH  = 2 ** ADDR_W;

    color_t            r_buf [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [PCNT_W-1:0] r_pcnt;
    logic              r_wr_err;

    logic              w_idle_st;
    logic              w_wr_ok;
    logic              w_last_px;
    logic              w_pause_end;
    logic              w_tx_valid;
    logic              w_tx_ready;
    logic              w_tx_out;
    logic              w_tx_idle;
    color_t            w_tx_word;

    assign w_idle_st   = (r_state == IDLE);
    assign w_wr_ok     = bus.wr_en && w_idle_st && (32'(bus.wr_addr) < NUM_PIXELS);
    assign w_last_px   = (32'(r_idx) == NUM_PIXELS - 1);
    assign w_pause_end = (r_state == PAUSE) && (r_pcnt == PCNT_W'(PAUSE_TICKS - 1));
    assign w_tx_valid  = (r_state == LOAD);
    assign w_tx_word   = r_buf[r_idx];

    assign bus.busy   = !w_idle_st;
    assign bus.done   = w_pause_end;
    assign bus.wr_err = r_wr_err;
    assign bus.out    = w_tx_out;

    // Writes land at the same edge that samples start, so a frame started together
    // with a write already carries the new colour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_buf[bus.wr_addr] <= pack_grb(bus.wr_r, bus.wr_g, bus.wr_b);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_pcnt   <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= bus.wr_en && !w_wr_ok;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                    end
                end
                LOAD: begin
                    // valid is held in LOAD, so ready alone means this pixel was taken
                    if (w_tx_ready) begin
                        if (w_last_px) begin
                            r_state <= DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_tx_idle) begin
                        r_state <= PAUSE;
                        r_pcnt  <= '0;
                    end
                end
                PAUSE: begin
                    if (w_pause_end) begin
                        r_state <= IDLE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    strip_bit_tx #(
        .DATA_TICKS (DATA_TICKS),
        .T0H        (T0H),
        .T1H        (T1H)
    ) u_bit_tx (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_tx_valid),
        .i_word  (w_tx_word),
        .o_ready (w_tx_ready),
        .o_out   (w_tx_out),
        .o_idle  (w_tx_idle)
    );

endmodule

// File: tb/tb_strip_sequencer.sv
// tb/tb_strip_sequencer.sv - self-checking bench for strip_sequencer with a 2-pixel buffer
module tb_strip_sequencer;

    localparam int NP = 2;
    localparam int AW = 3;
    localparam int DT = 6;
    localparam int PT = 12;
    localparam int FB = NP * 24;
    localparam logic [5:0] PAT1 = 6'b111100;
    localparam logic [5:0] PAT0 = 6'b110000;

    logic clk;
    logic rst;

    strip_sequencer_if #(.ADDR_W(AW)) bus ();

    strip_sequencer #(
        .NUM_PIXELS (NP),
        .ADDR_W     (AW),
        .DATA_TICKS (DT),
        .PAUSE_TICKS(PT),
        .T0H        (2),
        .T1H        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_run;
    int          n_fail;
    int          err_cnt;
    logic        obs[$];
    logic        exp_q[$];
    logic [23:0] model [NP];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.wr_err === 1'b1) err_cnt++;
    end

    function automatic void push_frame();
        for (int p = 0; p < NP; p++)
            for (int b = 23; b >= 0; b--)
                exp_q.push_back(model[p][b]);
    endfunction

    function automatic logic [5:0] get_chunk(input int base);
        logic [5:0] v;
        v = 'x;
        for (int k = 0; k < DT; k++) begin
            if (base >= 0 && base + k < obs.size()) v = {v[4:0], obs[base + k]};
            else v = {v[4:0], 1'bx};
        end
        return v;
    endfunction

    // Records the line once per cycle, index 0 being the cycle after start is sampled.
    task automatic capture(input int max_cyc, output int rise, output int dn);
        rise = -1;
        dn   = -1;
        obs.delete();
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            obs.push_back(bus.out);
            if (bus.out === 1'b1 && rise < 0) rise = i;
            if (bus.done === 1'b1) begin
                dn = i;
                break;
            end
        end
    endtask

    task automatic write_px(input int a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_r    = r;
        bus.wr_g    = g;
        bus.wr_b    = b;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({bus.out, bus.busy, bus.done, bus.wr_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold got %b want 0000", {bus.out, bus.busy, bus.done, bus.wr_err});
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_run++;
            if ({bus.out, bus.busy, bus.done, bus.wr_err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d got %b want 0000", i, {bus.out, bus.busy, bus.done, bus.wr_err});
            end
        end
    endtask

    task automatic test_frame();
        int rise, dn, e0;
        logic eb;
        logic [5:0] got;
        e0 = err_cnt;
        write_px(0, 8'h55, 8'h55, 8'h55);
        model[0] = {8'h55, 8'h55, 8'h55};
        write_px(1, 8'hFF, 8'h00, 8'hA5);
        model[1] = {8'h00, 8'hFF, 8'hA5};
        @(negedge clk);
        bus.start = 1'b1;
        push_frame();
        capture(400, rise, dn);
        n_run++;
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL frame_wr_err got %0d want 0", err_cnt - e0); end
        n_run++;
        if (rise !== 2) begin n_fail++; $display("FAIL frame_latency got %0d want 2", rise); end
        n_run++;
        if (dn - rise !== FB * DT + PT) begin n_fail++; $display("FAIL frame_length got %0d want %0d", dn - rise, FB * DT + PT); end
        for (int b = 0; b < FB; b++) begin
            eb = exp_q.pop_front();
            got = get_chunk(rise + b * DT);
            n_run++;
            if (got !== (eb ? PAT1 : PAT0)) begin
                n_fail++;
                $display("FAIL frame_bit%0d got %b want %b", b, got, eb ? PAT1 : PAT0);
            end
        end
    endtask

    task automatic test_busy_drop();
        int rise, dn, e0;
        logic eb, quiet;
        logic [5:0] got;
        e0 = err_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        push_frame();
        fork
            capture(400, rise, dn);
            begin
                repeat (40) @(negedge clk);
                bus.start = 1'b1;
                bus.wr_en = 1'b1; bus.wr_addr = AW'(1);
                bus.wr_r = 8'h12; bus.wr_g = 8'h34; bus.wr_b = 8'h56;
                @(negedge clk);
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
                repeat (100) @(negedge clk);
                bus.wr_en = 1'b1; bus.wr_addr = AW'(1);
                bus.wr_r = 8'h00; bus.wr_g = 8'hFF; bus.wr_b = 8'h00;
                @(negedge clk);
                bus.wr_en = 1'b0;
            end
        join
        n_run++;
        if (dn - rise !== FB * DT + PT) begin n_fail++; $display("FAIL busy_length got %0d want %0d", dn - rise, FB * DT + PT); end
        for (int b = 0; b < FB; b++) begin
            eb = exp_q.pop_front();
            got = get_chunk(rise + b * DT);
            n_run++;
            if (got !== (eb ? PAT1 : PAT0)) begin
                n_fail++;
                $display("FAIL busy_bit%0d got %b want %b", b, got, eb ? PAT1 : PAT0);
            end
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        n_run++;
        if (err_cnt - e0 !== 2) begin n_fail++; $display("FAIL busy_wr_err got %0d want 2", err_cnt - e0); end
        n_run++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL busy_no_restart got %b want 1", quiet); end
    endtask

    task automatic test_addr_and_same_cycle();
        int rise, dn, e0;
        logic eb;
        logic [5:0] got;
        e0 = err_cnt;
        write_px(3, 8'h11, 8'h22, 8'h33);
        @(negedge clk);
        n_run++;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL addr_wr_err got %0d want 1", err_cnt - e0); end
        bus.wr_en = 1'b1; bus.wr_addr = AW'(0);
        bus.wr_r = 8'h00; bus.wr_g = 8'h00; bus.wr_b = 8'h00;
        bus.start = 1'b1;
        model[0] = 24'h000000;
        push_frame();
        capture(400, rise, dn);
        n_run++;
        if (rise !== 2) begin n_fail++; $display("FAIL same_latency got %0d want 2", rise); end
        for (int b = 0; b < FB; b++) begin
            eb = exp_q.pop_front();
            got = get_chunk(rise + b * DT);
            n_run++;
            if (got !== (eb ? PAT1 : PAT0)) begin
                n_fail++;
                $display("FAIL same_bit%0d got %b want %b", b, got, eb ? PAT1 : PAT0);
            end
        end
    endtask

    task automatic test_mid_reset();
        int rise, dn;
        logic eb;
        logic [5:0] got;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i <= 182; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
        end
        n_run++;
        if (bus.out !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got %b want 1", bus.out); end
        #1 rst = 1'b0;
        #1;
        n_run++;
        if ({bus.out, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_now got %b want 000", {bus.out, bus.busy, bus.done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model[0] = '0;
        model[1] = '0;
        @(negedge clk);
        bus.start = 1'b1;
        push_frame();
        capture(400, rise, dn);
        n_run++;
        if (dn - rise !== FB * DT + PT) begin n_fail++; $display("FAIL midrst_length got %0d want %0d", dn - rise, FB * DT + PT); end
        for (int b = 0; b < FB; b++) begin
            eb = exp_q.pop_front();
            got = get_chunk(rise + b * DT);
            n_run++;
            if (got !== (eb ? PAT1 : PAT0)) begin
                n_fail++;
                $display("FAIL midrst_bit%0d got %b want %b", b, got, eb ? PAT1 : PAT0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rise_a, dn_a, rise_b, dn_b, gap;
        logic eb;
        logic [5:0] got;
        logic [23:0] v;
        for (int p = 0; p < NP; p++) begin
            v = 24'($urandom);
            write_px(p, v[15:8], v[23:16], v[7:0]);
            model[p] = v;
        end
        @(negedge clk);
        bus.start = 1'b1;
        push_frame();
        capture(400, rise_a, dn_a);
        for (int b = 0; b < FB; b++) begin
            eb = exp_q.pop_front();
            got = get_chunk(rise_a + b * DT);
            n_run++;
            if (got !== (eb ? PAT1 : PAT0)) begin
                n_fail++;
                $display("FAIL b2b_a_bit%0d got %b want %b", b, got, eb ? PAT1 : PAT0);
            end
        end
        gap = dn_a - (rise_a + FB * DT) + 2;
        @(negedge clk);
        bus.start = 1'b1;
        push_frame();
        capture(400, rise_b, dn_b);
        gap = gap + rise_b;
        n_run++;
        if (rise_b !== 2) begin n_fail++; $display("FAIL b2b_latency got %0d want 2", rise_b); end
        n_run++;
        if (!(gap >= PT)) begin n_fail++; $display("FAIL b2b_gap got %0d want >= %0d", gap, PT); end
        n_run++;
        if (dn_b - rise_b !== FB * DT + PT) begin n_fail++; $display("FAIL b2b_length got %0d want %0d", dn_b - rise_b, FB * DT + PT); end
        for (int b = 0; b < FB; b++) begin
            eb = exp_q.pop_front();
            got = get_chunk(rise_b + b * DT);
            n_run++;
            if (got !== (eb ? PAT1 : PAT0)) begin
                n_fail++;
                $display("FAIL b2b_b_bit%0d got %b want %b", b, got, eb ? PAT1 : PAT0);
            end
        end
    endtask

    initial begin
        n_run       = 0;
        n_fail      = 0;
        err_cnt     = 0;
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_r    = '0;
        bus.wr_g    = '0;
        bus.wr_b    = '0;
        bus.start   = 1'b0;
        model[0]    = '0;
        model[1]    = '0;
        test_reset();
        test_frame();
        test_busy_drop();
        test_addr_and_same_cycle();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
